// File: rtl/pipeline_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_pkg
// Shared definitions for the five-stage pipeline hazard controller: the
// hazard FSM state encoding (also exported on HAZARD_STATE for debug) and
// the default values of the controller parameters.
// -----------------------------------------------------------------------------
package pipeline_hazard_pkg;

   // Hazard FSM states; the numeric values are visible on HAZARD_STATE.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DMISS = 2'd1,
      ST_IMISS = 2'd2
   } hazard_state_e;

   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam int DEF_MISS_TIMEOUT   = 64;
   localparam int DEF_COUNTER_WIDTH  = 32;

endpackage : pipeline_hazard_pkg

// File: rtl/pipeline_hazard_controller_event_counter.sv
// -----------------------------------------------------------------------------
// hazard_event_counter
// Saturating up-counter used for the controller's performance counters.
// Holds at all-ones instead of wrapping.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, clears the count
//   inc_en  - add one this cycle (ignored once saturated)
//   count   - current count, registered
// -----------------------------------------------------------------------------
module hazard_event_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   // Count register with saturation at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {WIDTH{1'b0}};
      end else if (inc_en && (count != ALL_ONES)) begin
         count <= count + ONE;
      end else begin
         count <= count;
      end
   end

endmodule : hazard_event_counter

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Stall/flush controller for a five-stage pipeline. Resolves data-cache
// misses, taken branches, load-use dependencies and instruction-cache misses
// with a three-state FSM (RUN / DMISS / IMISS). Stall and clear controls are
// combinational from the current state and inputs; performance counters and
// the sticky timeout flag are registered.
//
// Ports:
//   CLK, RST                      - clock, synchronous active-high reset
//   RS1_ADDRESS, RS2_ADDRESS      - source registers of the ID instruction
//   RD_ADDRESS_EX                 - destination register of the EX instruction
//   DATA_CACHE_READ_EX            - load code in EX (non-zero = load)
//   BRANCH_TAKEN_EX               - taken branch/jump resolved in EX
//   DATA_CACHE_ACCESS_MEM         - MEM instruction accesses the data cache
//   DATA_CACHE_READY              - data cache hit/complete
//   INSTRUCTION_CACHE_READY       - instruction cache hit/complete
//   STALL_*                       - hold PC / IF / ID / EX / MEM registers
//   CLEAR_*                       - load a bubble into ID / EX / MEM
//   STALL_CYCLE_COUNT             - saturating count of cycles with any stall
//   FLUSH_COUNT                   - saturating count of branch flushes
//   TIMEOUT_ERROR                 - sticky data-cache miss timeout
//   HAZARD_STATE                  - current FSM state (debug)
// -----------------------------------------------------------------------------
module pipeline_hazard_controller
   import pipeline_hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int MISS_TIMEOUT   = DEF_MISS_TIMEOUT,
   parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [REG_ADDR_WIDTH-1:0] RS1_ADDRESS,
   input  logic [REG_ADDR_WIDTH-1:0] RS2_ADDRESS,
   input  logic [REG_ADDR_WIDTH-1:0] RD_ADDRESS_EX,
   input  logic [2:0]                DATA_CACHE_READ_EX,
   input  logic                      BRANCH_TAKEN_EX,
   input  logic                      DATA_CACHE_ACCESS_MEM,
   input  logic                      DATA_CACHE_READY,
   input  logic                      INSTRUCTION_CACHE_READY,
   output logic                      STALL_PROGRAM_COUNTER,
   output logic                      STALL_FETCH_STAGE,
   output logic                      STALL_DECODING_STAGE,
   output logic                      STALL_EXECUTION_STAGE,
   output logic                      STALL_MEMORY_STAGE,
   output logic                      CLEAR_DECODING_STAGE,
   output logic                      CLEAR_EXECUTION_STAGE,
   output logic                      CLEAR_MEMORY_STAGE,
   output logic [COUNTER_WIDTH-1:0]  STALL_CYCLE_COUNT,
   output logic [COUNTER_WIDTH-1:0]  FLUSH_COUNT,
   output logic                      TIMEOUT_ERROR,
   output logic [1:0]                HAZARD_STATE
);

   // Timeout counter only needs to reach MISS_TIMEOUT.
   localparam int            TO_W    = $clog2(MISS_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MISS_TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MISS_TIMEOUT);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   hazard_state_e     state_r;
   hazard_state_e     state_next_s;
   logic [TO_W-1:0]   timeout_cnt_r;
   logic              timeout_err_r;

   logic              data_miss_s;
   logic              load_use_s;
   logic              dmiss_entry_s;
   logic              stall_any_s;
   logic              flush_inc_s;

   logic              stall_pc_s;
   logic              stall_if_s;
   logic              stall_id_s;
   logic              stall_ex_s;
   logic              stall_mem_s;
   logic              clear_id_s;
   logic              clear_ex_s;
   logic              clear_mem_s;

   // Hazard conditions seen this cycle. A load writing x0 never creates a
   // dependency because x0 is hard-wired to zero.
   assign data_miss_s = DATA_CACHE_ACCESS_MEM && !DATA_CACHE_READY;
   assign load_use_s  = (DATA_CACHE_READ_EX != 3'b000)
                     && (RD_ADDRESS_EX != {REG_ADDR_WIDTH{1'b0}})
                     && ((RD_ADDRESS_EX == RS1_ADDRESS) || (RD_ADDRESS_EX == RS2_ADDRESS));

   // Next-state and stall/clear decode. Priority outside DMISS:
   // data miss > branch > load-use > instruction miss.
   always_comb begin
      state_next_s = state_r;
      flush_inc_s  = 1'b0;
      stall_pc_s   = 1'b0;
      stall_if_s   = 1'b0;
      stall_id_s   = 1'b0;
      stall_ex_s   = 1'b0;
      stall_mem_s  = 1'b0;
      clear_id_s   = 1'b0;
      clear_ex_s   = 1'b0;
      clear_mem_s  = 1'b0;

      if (RST) begin
         // Flush every pipeline register while in reset; nothing is held.
         clear_id_s   = 1'b1;
         clear_ex_s   = 1'b1;
         clear_mem_s  = 1'b1;
         state_next_s = ST_RUN;
      end else begin
         case (state_r)
            ST_DMISS: begin
               if (!DATA_CACHE_READY) begin
                  stall_pc_s   = 1'b1;
                  stall_if_s   = 1'b1;
                  stall_id_s   = 1'b1;
                  stall_ex_s   = 1'b1;
                  stall_mem_s  = 1'b1;
                  clear_mem_s  = 1'b1;
                  state_next_s = ST_DMISS;
               end else begin
                  state_next_s = ST_RUN;
               end
            end
            ST_RUN, ST_IMISS: begin
               if (data_miss_s) begin
                  stall_pc_s   = 1'b1;
                  stall_if_s   = 1'b1;
                  stall_id_s   = 1'b1;
                  stall_ex_s   = 1'b1;
                  stall_mem_s  = 1'b1;
                  clear_mem_s  = 1'b1;
                  state_next_s = ST_DMISS;
               end else if (BRANCH_TAKEN_EX) begin
                  // PC is left free so the branch target loads; the wrong-path
                  // instructions in ID and EX are squashed.
                  clear_id_s   = 1'b1;
                  clear_ex_s   = 1'b1;
                  flush_inc_s  = 1'b1;
                  state_next_s = ST_RUN;
               end else if (load_use_s) begin
                  // One-cycle bubble into EX; state is not disturbed.
                  stall_pc_s   = 1'b1;
                  stall_if_s   = 1'b1;
                  stall_id_s   = 1'b1;
                  clear_ex_s   = 1'b1;
                  state_next_s = state_r;
               end else if (!INSTRUCTION_CACHE_READY) begin
                  stall_pc_s   = 1'b1;
                  stall_if_s   = 1'b1;
                  clear_id_s   = 1'b1;
                  state_next_s = ST_IMISS;
               end else begin
                  state_next_s = ST_RUN;
               end
            end
            default: begin
               state_next_s = ST_RUN;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   assign dmiss_entry_s = (state_r != ST_DMISS) && (state_next_s == ST_DMISS);

   // Miss-duration counter and sticky timeout flag. The counter restarts on
   // every entry into DMISS and counts each DMISS cycle; the flag only clears
   // through reset so software can see a past timeout.
   always_ff @(posedge CLK) begin
      if (RST) begin
         timeout_cnt_r <= {TO_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         if (dmiss_entry_s) begin
            timeout_cnt_r <= {TO_W{1'b0}};
         end else if ((state_r == ST_DMISS) && (timeout_cnt_r != TO_MAX)) begin
            timeout_cnt_r <= timeout_cnt_r + TO_ONE;
         end else begin
            timeout_cnt_r <= timeout_cnt_r;
         end

         if ((state_r == ST_DMISS) && (timeout_cnt_r == TO_LAST)) begin
            timeout_err_r <= 1'b1;
         end else begin
            timeout_err_r <= timeout_err_r;
         end
      end
   end

   assign stall_any_s = stall_pc_s | stall_if_s | stall_id_s | stall_ex_s | stall_mem_s;

   hazard_event_counter #(
      .WIDTH (COUNTER_WIDTH)
   ) u_stall_counter (
      .clk    (CLK),
      .rst    (RST),
      .inc_en (stall_any_s),
      .count  (STALL_CYCLE_COUNT)
   );

   hazard_event_counter #(
      .WIDTH (COUNTER_WIDTH)
   ) u_flush_counter (
      .clk    (CLK),
      .rst    (RST),
      .inc_en (flush_inc_s),
      .count  (FLUSH_COUNT)
   );

   assign STALL_PROGRAM_COUNTER = stall_pc_s;
   assign STALL_FETCH_STAGE     = stall_if_s;
   assign STALL_DECODING_STAGE  = stall_id_s;
   assign STALL_EXECUTION_STAGE = stall_ex_s;
   assign STALL_MEMORY_STAGE    = stall_mem_s;
   assign CLEAR_DECODING_STAGE  = clear_id_s;
   assign CLEAR_EXECUTION_STAGE = clear_ex_s;
   assign CLEAR_MEMORY_STAGE    = clear_mem_s;
   assign TIMEOUT_ERROR         = timeout_err_r;
   assign HAZARD_STATE          = state_r;

endmodule : pipeline_hazard_controller

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Directed self-checking bench for pipeline_hazard_controller. Inputs change
// on the falling edge; combinational controls are checked 1 ns later and the
// registered state/counters 1 ns after the following rising edge.
// Control vector layout: {STALL PC,IF,ID,EX,MEM, CLEAR ID,EX,MEM}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

   localparam int CW = 4;

   localparam logic [7:0] CTL_IDLE = 8'b00000_000;
   localparam logic [7:0] CTL_RST  = 8'b00000_111;
   localparam logic [7:0] CTL_DM   = 8'b11111_001;
   localparam logic [7:0] CTL_BR   = 8'b00000_110;
   localparam logic [7:0] CTL_LU   = 8'b11100_010;
   localparam logic [7:0] CTL_IM   = 8'b11000_100;

   logic          clk;
   logic          rst;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [4:0]    rd_ex;
   logic [2:0]    rd_code;
   logic          branch;
   logic          access_mem;
   logic          dready;
   logic          iready;
   logic          s_pc, s_if, s_id, s_ex, s_mem;
   logic          c_id, c_ex, c_mem;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
   logic          timeout;
   logic [1:0]    hstate;
   logic [7:0]    ctl;

   int tests_run    = 0;
   int tests_failed = 0;

   assign ctl = {s_pc, s_if, s_id, s_ex, s_mem, c_id, c_ex, c_mem};

   pipeline_hazard_controller #(
      .REG_ADDR_WIDTH (5),
      .MISS_TIMEOUT   (64),
      .COUNTER_WIDTH  (CW)
   ) dut (
      .CLK                     (clk),
      .RST                     (rst),
      .RS1_ADDRESS             (rs1),
      .RS2_ADDRESS             (rs2),
      .RD_ADDRESS_EX           (rd_ex),
      .DATA_CACHE_READ_EX      (rd_code),
      .BRANCH_TAKEN_EX         (branch),
      .DATA_CACHE_ACCESS_MEM   (access_mem),
      .DATA_CACHE_READY        (dready),
      .INSTRUCTION_CACHE_READY (iready),
      .STALL_PROGRAM_COUNTER   (s_pc),
      .STALL_FETCH_STAGE       (s_if),
      .STALL_DECODING_STAGE    (s_id),
      .STALL_EXECUTION_STAGE   (s_ex),
      .STALL_MEMORY_STAGE      (s_mem),
      .CLEAR_DECODING_STAGE    (c_id),
      .CLEAR_EXECUTION_STAGE   (c_ex),
      .CLEAR_MEMORY_STAGE      (c_mem),
      .STALL_CYCLE_COUNT       (stall_cnt),
      .FLUSH_COUNT             (flush_cnt),
      .TIMEOUT_ERROR           (timeout),
      .HAZARD_STATE            (hstate)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (obs !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rs1        = 5'd0;
      rs2        = 5'd0;
      rd_ex      = 5'd0;
      rd_code    = 3'b000;
      branch     = 1'b0;
      access_mem = 1'b0;
      dready     = 1'b1;
      iready     = 1'b1;
   endtask

   task automatic load_use_on_rs2();
      rd_ex   = 5'd4;
      rd_code = 3'b010;
      rs1     = 5'd7;
      rs2     = 5'd4;
   endtask

   // Called on a falling edge with inputs already applied; ends on the next
   // falling edge after checking controls and the state that was loaded.
   task automatic cyc(input string tag, input logic [7:0] exp_ctl, input logic [1:0] exp_state);
      #1;
      check({tag, "_ctl"}, {24'd0, ctl}, {24'd0, exp_ctl});
      @(posedge clk);
      #1;
      check({tag, "_state"}, {30'd0, hstate}, {30'd0, exp_state});
      @(negedge clk);
   endtask

   task automatic counters(input string tag, input int exp_stall, input int exp_flush);
      check({tag, "_stallcnt"}, {28'd0, stall_cnt}, exp_stall);
      check({tag, "_flushcnt"}, {28'd0, flush_cnt}, exp_flush);
   endtask

   initial begin
      // Reset state.
      idle();
      rst = 1'b1;
      cyc("rst", CTL_RST, 2'd0);
      counters("rst", 0, 0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);

      rst = 1'b0;
      cyc("idle", CTL_IDLE, 2'd0);

      // Load-use on RS2: one-cycle stall and EX bubble.
      load_use_on_rs2();
      cyc("lu_rs2", CTL_LU, 2'd0);
      counters("lu_rs2", 1, 0);
      idle();
      cyc("lu_done", CTL_IDLE, 2'd0);
      counters("lu_done", 1, 0);

      // Destination x0 never causes a dependency.
      load_use_on_rs2();
      rd_ex = 5'd0;
      cyc("lu_rd0", CTL_IDLE, 2'd0);
      idle();
      rd_code = 3'b010;
      cyc("lu_all0", CTL_IDLE, 2'd0);

      // Load-use on RS1, and the same match without a load.
      idle();
      rd_ex   = 5'd9;
      rs1     = 5'd9;
      rd_code = 3'b001;
      cyc("lu_rs1", CTL_LU, 2'd0);
      rd_code = 3'b000;
      cyc("no_load", CTL_IDLE, 2'd0);
      counters("lu_rs1", 2, 0);

      // Data miss for 5 cycles, then ready.
      idle();
      rst = 1'b1;
      cyc("rst2", CTL_RST, 2'd0);
      counters("rst2", 0, 0);
      rst        = 1'b0;
      access_mem = 1'b1;
      dready     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc("dmiss", CTL_DM, 2'd1);
      end
      dready = 1'b1;
      cyc("dmiss_end", CTL_IDLE, 2'd0);
      counters("dmiss", 5, 0);
      check("dmiss_timeout", {31'd0, timeout}, 32'd0);

      // Data miss outranks branch, load-use and instruction miss.
      load_use_on_rs2();
      access_mem = 1'b1;
      dready     = 1'b0;
      branch     = 1'b1;
      iready     = 1'b0;
      cyc("dm_pri", CTL_DM, 2'd1);
      idle();
      access_mem = 1'b1;
      cyc("dm_pri_end", CTL_IDLE, 2'd0);
      counters("dm_pri", 6, 0);

      // Branch with load-use and instruction miss: branch only.
      idle();
      load_use_on_rs2();
      branch = 1'b1;
      iready = 1'b0;
      cyc("br_lu_im", CTL_BR, 2'd0);
      counters("br_lu_im", 6, 1);

      // Instruction miss and behaviour inside IMISS.
      idle();
      iready = 1'b0;
      cyc("im_enter", CTL_IM, 2'd2);
      cyc("im_hold", CTL_IM, 2'd2);
      load_use_on_rs2();
      cyc("im_lu", CTL_LU, 2'd2);
      idle();
      iready = 1'b0;
      branch = 1'b1;
      cyc("im_br", CTL_BR, 2'd0);
      counters("im_br", 9, 2);
      branch = 1'b0;
      cyc("im_again", CTL_IM, 2'd2);
      iready = 1'b1;
      cyc("im_exit", CTL_IDLE, 2'd0);
      counters("im_exit", 10, 2);

      // Reset during IMISS.
      iready = 1'b0;
      cyc("im_pre_rst", CTL_IM, 2'd2);
      rst = 1'b1;
      cyc("rst_im", CTL_RST, 2'd0);
      counters("rst_im", 0, 0);
      rst    = 1'b0;
      iready = 1'b1;
      cyc("post_rst_im", CTL_IDLE, 2'd0);

      // Reset during DMISS.
      access_mem = 1'b1;
      dready     = 1'b0;
      cyc("dm_pre_rst", CTL_DM, 2'd1);
      rst = 1'b1;
      cyc("rst_dm", CTL_RST, 2'd0);
      rst = 1'b0;
      idle();
      cyc("post_rst_dm", CTL_IDLE, 2'd0);
      counters("post_rst_dm", 0, 0);

      // Long miss: timeout flag sets, is sticky, and stall counter saturates.
      access_mem = 1'b1;
      dready     = 1'b0;
      for (int i = 0; i < 70; i++) begin
         cyc("to_wait", CTL_DM, 2'd1);
         if (i == 4) begin
            check("to_early", {31'd0, timeout}, 32'd0);
         end
      end
      check("to_set", {31'd0, timeout}, 32'd1);
      counters("to_sat", 15, 0);
      dready = 1'b1;
      cyc("to_ready", CTL_IDLE, 2'd0);
      check("to_after_ready", {31'd0, timeout}, 32'd1);
      idle();
      cyc("to_idle", CTL_IDLE, 2'd0);
      check("to_sticky", {31'd0, timeout}, 32'd1);
      rst = 1'b1;
      cyc("to_rst", CTL_RST, 2'd0);
      check("to_cleared", {31'd0, timeout}, 32'd0);
      rst = 1'b0;

      // Flush counter saturation.
      branch = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc("br_sat", CTL_BR, 2'd0);
         if (i == 14) begin
            counters("br_15", 0, 15);
         end
      end
      counters("br_sat", 0, 15);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pipeline_hazard_controller
